// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage register: control-vector bit
// positions and the stage occupancy state encoding.
package pipe_pkg;

   // Bit positions inside the default 4-bit control vector
   localparam int CTRL_WMEM = 0;
   localparam int CTRL_RMEM = 1;
   localparam int CTRL_WREG = 2;
   localparam int CTRL_JMP  = 3;

   // Stage occupancy: nothing held, main entry full, main and skid full
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline stage: valid flag plus data/dest/ctrl.
// Clearing drops only the valid flag so the payload keeps its last value.
module pipe_slot #(
   parameter int DATA_W = 32,
   parameter int DEST_W = 4,
   parameter int CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d_data,
   input  logic [DEST_W-1:0] d_dest,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [DEST_W-1:0] dest,
   output logic [CTRL_W-1:0] ctrl
);

   logic              valid_reg;
   logic [DATA_W-1:0] data_reg;
   logic [DEST_W-1:0] dest_reg;
   logic [CTRL_W-1:0] ctrl_reg;

   // Load takes priority over clear; reset zeroes the whole entry
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
         dest_reg  <= '0;
         ctrl_reg  <= '0;
      end else if (load) begin
         valid_reg <= 1'b1;
         data_reg  <= d_data;
         dest_reg  <= d_dest;
         ctrl_reg  <= d_ctrl;
      end else if (clear) begin
         valid_reg <= 1'b0;
      end
   end

   assign valid = valid_reg;
   assign data  = data_reg;
   assign dest  = dest_reg;
   assign ctrl  = ctrl_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, optional second
// (skid) entry, synchronous flush that turns the stage into a bubble,
// and a forwarding tap driven from the presented item.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int DEST_W   = 4,
   parameter int CTRL_W   = 4,
   parameter int WREG_BIT = CTRL_WREG,
   parameter int SKID     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DEST_W-1:0] in_dest,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [DEST_W-1:0] out_dest,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic              fwd_valid,
   output logic [DEST_W-1:0] fwd_dest,
   output logic [DATA_W-1:0] fwd_data,
   output logic [1:0]        occupancy
);

   stage_state_e state_reg, state_next;
   logic         in_ready_reg;

   logic         in_fire, out_fire;
   logic         main_load, main_clr, main_sel_skid;
   logic         skid_load, skid_clr;

   logic              main_valid;
   logic [DATA_W-1:0] main_data;
   logic [DEST_W-1:0] main_dest;
   logic [CTRL_W-1:0] main_ctrl;

   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
   logic [DEST_W-1:0] skid_dest;
   logic [CTRL_W-1:0] skid_ctrl;

   logic [DATA_W-1:0] main_d_data;
   logic [DEST_W-1:0] main_d_dest;
   logic [CTRL_W-1:0] main_d_ctrl;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   // Next-state and slot control; flush beats both handshakes
   always_comb begin
      state_next    = state_reg;
      main_load     = 1'b0;
      main_clr      = 1'b0;
      main_sel_skid = 1'b0;
      skid_load     = 1'b0;
      skid_clr      = 1'b0;
      if (flush) begin
         state_next = ST_EMPTY;
         main_clr   = 1'b1;
         skid_clr   = 1'b1;
      end else begin
         case (state_reg)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_next = ST_ONE;
                  main_load  = 1'b1;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_load = 1'b1;
               end else if (in_fire && (SKID == 1)) begin
                  state_next = ST_TWO;
                  skid_load  = 1'b1;
               end else if (out_fire) begin
                  state_next = ST_EMPTY;
                  main_clr   = 1'b1;
               end
            end
            ST_TWO: begin
               if (out_fire) begin
                  state_next    = ST_ONE;
                  main_load     = 1'b1;
                  main_sel_skid = 1'b1;
                  skid_clr      = 1'b1;
               end
            end
            default: begin
               state_next = ST_EMPTY;
               main_clr   = 1'b1;
               skid_clr   = 1'b1;
            end
         endcase
      end
   end

   // State register plus the registered ready (low only when both entries are full)
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_EMPTY;
         in_ready_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         in_ready_reg <= (state_next != ST_TWO);
      end
   end

   // Main entry reloads from the skid when draining the second item
   assign main_d_data = main_sel_skid ? skid_data : in_data;
   assign main_d_dest = main_sel_skid ? skid_dest : in_dest;
   assign main_d_ctrl = main_sel_skid ? skid_ctrl : in_ctrl;

   pipe_slot #(
      .DATA_W (DATA_W),
      .DEST_W (DEST_W),
      .CTRL_W (CTRL_W)
   ) u_main (
      .clk    (clk),
      .rst    (rst),
      .load   (main_load),
      .clear  (main_clr),
      .d_data (main_d_data),
      .d_dest (main_d_dest),
      .d_ctrl (main_d_ctrl),
      .valid  (main_valid),
      .data   (main_data),
      .dest   (main_dest),
      .ctrl   (main_ctrl)
   );

   generate
      if (SKID == 1) begin : gen_skid
         pipe_slot #(
            .DATA_W (DATA_W),
            .DEST_W (DEST_W),
            .CTRL_W (CTRL_W)
         ) u_skid (
            .clk    (clk),
            .rst    (rst),
            .load   (skid_load),
            .clear  (skid_clr),
            .d_data (in_data),
            .d_dest (in_dest),
            .d_ctrl (in_ctrl),
            .valid  (skid_valid),
            .data   (skid_data),
            .dest   (skid_dest),
            .ctrl   (skid_ctrl)
         );
         // Ready comes straight from a flop; held low while in reset
         assign in_ready = in_ready_reg && !rst;
      end else begin : gen_no_skid
         assign skid_valid = 1'b0;
         assign skid_data  = '0;
         assign skid_dest  = '0;
         assign skid_ctrl  = '0;
         // Single entry: accept when empty or when the held item leaves this cycle
         assign in_ready = !rst && (!main_valid || out_ready);
      end
   endgenerate

   // Bubbles carry an all-zero control vector so no stray write/jump escapes
   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign out_dest  = main_dest;
   assign out_ctrl  = main_valid ? main_ctrl : '0;

   assign fwd_valid = out_valid && out_ctrl[WREG_BIT];
   assign fwd_dest  = out_dest;
   assign fwd_data  = out_data;

   assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: one instance with the skid entry,
// one without, stepped together from a single clock.
module tb_pipe_stage_skid;

   logic        clk = 1'b0;
   logic        rst;

   // Skid instance
   logic        flush, in_valid, in_ready, out_valid, out_ready, fwd_valid;
   logic [31:0] in_data, out_data, fwd_data;
   logic [3:0]  in_dest, out_dest, fwd_dest, in_ctrl, out_ctrl;
   logic [1:0]  occupancy;

   // Single-entry instance
   logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0, fwd_valid0;
   logic [31:0] in_data0, out_data0, fwd_data0;
   logic [3:0]  in_dest0, out_dest0, fwd_dest0, in_ctrl0, out_ctrl0;
   logic [1:0]  occupancy0;

   int pass_count = 0;
   int check_count = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.SKID(1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_dest(in_dest), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_dest(out_dest), .out_ctrl(out_ctrl),
      .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
      .occupancy(occupancy)
   );

   pipe_stage_skid #(.SKID(0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush0),
      .in_valid(in_valid0), .in_ready(in_ready0),
      .in_data(in_data0), .in_dest(in_dest0), .in_ctrl(in_ctrl0),
      .out_valid(out_valid0), .out_ready(out_ready0),
      .out_data(out_data0), .out_dest(out_dest0), .out_ctrl(out_ctrl0),
      .fwd_valid(fwd_valid0), .fwd_dest(fwd_dest0), .fwd_data(fwd_data0),
      .occupancy(occupancy0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_count++;
      assert (obs === exp) pass_count++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Advance one edge; inputs and checks sit 1 time unit after posedge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] de, input logic [3:0] c);
      in_valid = v;
      in_data  = d;
      in_dest  = de;
      in_ctrl  = c;
      if (v) $display("push data=0x%0h dest=%0d ctrl=%b out_ready=%b flush=%b", d, de, c, out_ready, flush);
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0, 4'h0, 4'h0);
      flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
      in_data0 = '0; in_dest0 = '0; in_ctrl0 = '0;

      // 1. Reset
      #1;
      check("rst_ready_pre", {31'b0, in_ready}, 32'd0);
      step();
      step();
      check("rst_ready", {31'b0, in_ready}, 32'd0);
      check("rst_ready0", {31'b0, in_ready0}, 32'd0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_dest", {28'b0, out_dest}, 32'd0);
      check("rst_out_ctrl", {28'b0, out_ctrl}, 32'd0);
      check("rst_occ", {30'b0, occupancy}, 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", {31'b0, in_ready}, 32'd1);
      check("post_rst_ready0", {31'b0, in_ready0}, 32'd1);

      // 2. Stream with out_ready=1
      out_ready = 1'b1;
      drive(1'b1, 32'h11, 4'd1, 4'b0100);
      step();
      check("s1_data", out_data, 32'h11);
      check("s1_dest", {28'b0, out_dest}, 32'd1);
      check("s1_valid", {31'b0, out_valid}, 32'd1);
      check("s1_occ", {30'b0, occupancy}, 32'd1);
      drive(1'b1, 32'h22, 4'd2, 4'b0100);
      step();
      check("s2_data", out_data, 32'h22);
      check("s2_dest", {28'b0, out_dest}, 32'd2);
      check("s2_occ", {30'b0, occupancy}, 32'd1);
      drive(1'b1, 32'h33, 4'd3, 4'b0100);
      step();
      check("s3_data", out_data, 32'h33);
      check("s3_dest", {28'b0, out_dest}, 32'd3);
      check("s3_occ", {30'b0, occupancy}, 32'd1);
      drive(1'b0, 32'h0, 4'd0, 4'b0);
      step();
      check("s_drain_valid", {31'b0, out_valid}, 32'd0);
      check("s_drain_ctrl", {28'b0, out_ctrl}, 32'd0);
      check("s_drain_keep", out_data, 32'h33);
      check("s_drain_occ", {30'b0, occupancy}, 32'd0);

      // 3. Skid fill and drain
      out_ready = 1'b0;
      drive(1'b1, 32'hA0, 4'd10, 4'b0000);
      step();
      check("k1_data", out_data, 32'hA0);
      check("k1_occ", {30'b0, occupancy}, 32'd1);
      check("k1_ready", {31'b0, in_ready}, 32'd1);
      drive(1'b1, 32'hB0, 4'd11, 4'b0000);
      step();
      check("k2_occ", {30'b0, occupancy}, 32'd2);
      check("k2_ready", {31'b0, in_ready}, 32'd0);
      check("k2_hold", out_data, 32'hA0);
      drive(1'b1, 32'hEE, 4'd14, 4'b0000);
      step();
      check("k3_hold", out_data, 32'hA0);
      check("k3_hold_dest", {28'b0, out_dest}, 32'd10);
      check("k3_occ", {30'b0, occupancy}, 32'd2);
      drive(1'b0, 32'h0, 4'd0, 4'b0);
      out_ready = 1'b1;
      #1;
      check("k4_first", out_data, 32'hA0);
      step();
      check("k5_second", out_data, 32'hB0);
      check("k5_dest", {28'b0, out_dest}, 32'd11);
      check("k5_occ", {30'b0, occupancy}, 32'd1);
      check("k5_ready", {31'b0, in_ready}, 32'd1);
      step();
      check("k6_valid", {31'b0, out_valid}, 32'd0);
      check("k6_occ", {30'b0, occupancy}, 32'd0);

      // 4. Flush from full, then from one entry with ready high
      out_ready = 1'b0;
      drive(1'b1, 32'h01, 4'd1, 4'b0100);
      step();
      drive(1'b1, 32'h02, 4'd2, 4'b0100);
      step();
      check("f0_occ", {30'b0, occupancy}, 32'd2);
      flush = 1'b1;
      drive(1'b1, 32'hCC, 4'd12, 4'b0100);
      step();
      check("f1_valid", {31'b0, out_valid}, 32'd0);
      check("f1_ctrl", {28'b0, out_ctrl}, 32'd0);
      check("f1_occ", {30'b0, occupancy}, 32'd0);
      check("f1_fwd", {31'b0, fwd_valid}, 32'd0);
      check("f1_ready", {31'b0, in_ready}, 32'd1);
      flush = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 32'h0, 4'd0, 4'b0);
      step();
      check("f2_valid", {31'b0, out_valid}, 32'd0);
      check("f2_keep", out_data, 32'h01);
      out_ready = 1'b0;
      drive(1'b1, 32'h05, 4'd5, 4'b0100);
      step();
      check("f3_occ", {30'b0, occupancy}, 32'd1);
      flush = 1'b1;
      drive(1'b1, 32'hCC, 4'd12, 4'b0100);
      step();
      check("f4_valid", {31'b0, out_valid}, 32'd0);
      check("f4_occ", {30'b0, occupancy}, 32'd0);
      check("f4_keep", out_data, 32'h05);
      flush = 1'b0;
      drive(1'b0, 32'h0, 4'd0, 4'b0);
      step();
      check("f5_valid", {31'b0, out_valid}, 32'd0);

      // 5. Forwarding tap
      out_ready = 1'b1;
      drive(1'b1, 32'hDEAD, 4'd5, 4'b0100);
      step();
      check("w1_fwd_valid", {31'b0, fwd_valid}, 32'd1);
      check("w1_fwd_dest", {28'b0, fwd_dest}, 32'd5);
      check("w1_fwd_data", fwd_data, 32'hDEAD);
      check("w1_ctrl", {28'b0, out_ctrl}, 32'h4);
      drive(1'b1, 32'hBEEF, 4'd6, 4'b0001);
      step();
      check("w2_fwd_valid", {31'b0, fwd_valid}, 32'd0);
      check("w2_ctrl", {28'b0, out_ctrl}, 32'h1);
      check("w2_valid", {31'b0, out_valid}, 32'd1);
      drive(1'b0, 32'h0, 4'd0, 4'b0);
      step();
      check("w3_fwd_valid", {31'b0, fwd_valid}, 32'd0);

      // 6. Single-entry variant: combinational ready
      out_ready0 = 1'b0;
      in_valid0 = 1'b1; in_data0 = 32'h77; in_dest0 = 4'd7; in_ctrl0 = 4'b0100;
      $display("push0 data=0x77 dest=7 ctrl=0100 out_ready=0");
      step();
      check("n1_valid", {31'b0, out_valid0}, 32'd1);
      check("n1_data", out_data0, 32'h77);
      check("n1_ready", {31'b0, in_ready0}, 32'd0);
      in_data0 = 32'h88; in_dest0 = 4'd8;
      $display("push0 data=0x88 dest=8 ctrl=0100 out_ready=1");
      #1;
      check("n2_ready_low", {31'b0, in_ready0}, 32'd0);
      out_ready0 = 1'b1;
      #1;
      check("n2_ready_high", {31'b0, in_ready0}, 32'd1);
      step();
      check("n3_data", out_data0, 32'h88);
      check("n3_valid", {31'b0, out_valid0}, 32'd1);
      check("n3_occ", {30'b0, occupancy0}, 32'd1);
      in_valid0 = 1'b0;
      out_ready0 = 1'b0;
      step();
      check("n4_hold", out_data0, 32'h88);
      check("n4_dest", {28'b0, out_dest0}, 32'd8);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
